// File: rtl/remote_arm_sequencer_pkg.sv
// Shared definitions for the remote arm sequencer: state encoding and
// channel slicing helper.
package remote_seq_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PRE    = 3'd1;
   localparam logic [2:0] S_ARM    = 3'd2;
   localparam logic [2:0] S_POST   = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd4;
   localparam logic [2:0] S_DISARM = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_PRE    = S_PRE,
      ST_ARM    = S_ARM,
      ST_POST   = S_POST,
      ST_RUN    = S_RUN,
      ST_DISARM = S_DISARM
   } state_e;

   // Bit offset of channel k within a flat bus of w-bit channels.
   function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

endpackage

// File: rtl/remote_arm_sequencer_phase_timer.sv
// Phase length counter: counts enabled cycles since the last clear and flags
// the final cycle of a phase whose length is given on len_i.
module phase_timer #(
   parameter int unsigned CNT_W = 26
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [CNT_W-1:0] len_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             tc_s;

   assign tc_s = enable_i && (cnt_q == (len_i - {{(CNT_W-1){1'b0}}, 1'b1}));
   assign tc_o = tc_s;

   // Next count: cleared on phase change, saturates at terminal count.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (enable_i && !tc_s) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/remote_arm_sequencer.sv
// Remote arm sequencer: drives a timed safe/arm/safe pattern on the stick
// channels after start, then passes live channels through until disarm/abort.
module remote_arm_sequencer
   import remote_seq_pkg::*;
#(
   parameter int unsigned     NUM_CH     = 4,
   parameter int unsigned     WIDTH      = 8,
   parameter int unsigned     ARM_CH     = 0,
   parameter logic [WIDTH-1:0] SAFE_VAL   = 8'h00,
   parameter logic [WIDTH-1:0] ARM_VAL    = 8'hFF,
   parameter logic [WIDTH-1:0] DISARM_VAL = 8'h00,
   parameter int unsigned     PRE_CYC    = 28_000_000,
   parameter int unsigned     ARM_CYC    = 26_000_000,
   parameter int unsigned     POST_CYC   = 1,
   parameter int unsigned     CNT_W      = 26
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    disarm,
   input  logic                    abort,
   input  logic [NUM_CH*WIDTH-1:0] ch_in,
   output logic [NUM_CH*WIDTH-1:0] ch_out,
   output logic                    busy,
   output logic                    armed,
   output logic                    done,
   output logic [2:0]              state_dbg
);

   state_e                  state_q;
   state_e                  state_d;
   logic                    done_d;
   logic                    tc_s;
   logic                    timed_s;
   logic [CNT_W-1:0]        len_s;
   logic [NUM_CH*WIDTH-1:0] ch_d;
   logic [NUM_CH*WIDTH-1:0] ch_out_q;
   logic                    busy_q;
   logic                    armed_q;
   logic                    done_q;

   // Phase length selection for the current timed state.
   always_comb begin
      len_s   = {CNT_W{1'b0}};
      timed_s = 1'b0;
      case (state_q)
         ST_PRE:    begin len_s = CNT_W'(PRE_CYC);  timed_s = 1'b1; end
         ST_ARM:    begin len_s = CNT_W'(ARM_CYC);  timed_s = 1'b1; end
         ST_POST:   begin len_s = CNT_W'(POST_CYC); timed_s = 1'b1; end
         ST_DISARM: begin len_s = CNT_W'(ARM_CYC);  timed_s = 1'b1; end
         default:   begin len_s = {CNT_W{1'b0}};    timed_s = 1'b0; end
      endcase
   end

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear_i  (state_d != state_q),
      .enable_i (timed_s),
      .len_i    (len_s),
      .tc_o     (tc_s)
   );

   // Next-state logic; abort overrides every request.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (start)  state_d = ST_PRE;    else state_d = state_q;
            ST_PRE:    if (tc_s)   state_d = ST_ARM;    else state_d = state_q;
            ST_ARM:    if (tc_s)   state_d = ST_POST;   else state_d = state_q;
            ST_POST:   if (tc_s)   begin state_d = ST_RUN;  done_d = 1'b1; end
                       else state_d = state_q;
            ST_RUN:    if (disarm) state_d = ST_DISARM; else state_d = state_q;
            ST_DISARM: if (tc_s)   begin state_d = ST_IDLE; done_d = 1'b1; end
                       else state_d = state_q;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Per-channel output value for the state being entered.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      localparam int unsigned LSB = ch_lsb(k, WIDTH);
      if (k == ARM_CH) begin : g_arm
         assign ch_d[LSB +: WIDTH] = (state_d == ST_RUN)    ? ch_in[LSB +: WIDTH] :
                                     (state_d == ST_ARM)    ? ARM_VAL :
                                     (state_d == ST_DISARM) ? DISARM_VAL : SAFE_VAL;
      end else begin : g_other
         assign ch_d[LSB +: WIDTH] = (state_d == ST_RUN) ? ch_in[LSB +: WIDTH] : SAFE_VAL;
      end
   end

   // State and output registers, all reflecting the state entered this edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         ch_out_q <= {NUM_CH{SAFE_VAL}};
         busy_q   <= 1'b0;
         armed_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ch_out_q <= ch_d;
         busy_q   <= (state_d == ST_PRE) || (state_d == ST_ARM) ||
                     (state_d == ST_POST) || (state_d == ST_DISARM);
         armed_q  <= (state_d == ST_RUN);
         done_q   <= done_d;
      end
   end

   assign ch_out    = ch_out_q;
   assign busy      = busy_q;
   assign armed     = armed_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_remote_arm_sequencer.sv
// Scoreboard bench for remote_arm_sequencer with a phase/countdown reference model.
module tb_remote_arm_sequencer;

   localparam int PRE  = 4;
   localparam int ARMC = 3;
   localparam int POST = 2;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start, disarm, abort;
   logic [31:0] ch_in;
   logic [31:0] ch_out;
   logic        busy, armed, done;
   logic [2:0]  state_dbg;

   remote_arm_sequencer #(
      .NUM_CH(4), .WIDTH(8), .ARM_CH(0),
      .SAFE_VAL(8'h00), .ARM_VAL(8'hFF), .DISARM_VAL(8'h00),
      .PRE_CYC(PRE), .ARM_CYC(ARMC), .POST_CYC(POST), .CNT_W(3)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .disarm(disarm),
      .abort(abort), .ch_in(ch_in), .ch_out(ch_out), .busy(busy),
      .armed(armed), .done(done), .state_dbg(state_dbg)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] ch;
      logic        busy;
      logic        armed;
      logic        done;
      logic [2:0]  st;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   // Reference model: phase 0..5 and cycles remaining in the current phase.
   int   ph  = 0;
   int   rem = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Applies one clock edge of the specification's rules to the model.
   task automatic model(input logic s, input logic d, input logic a, input logic [31:0] c);
      exp_t e;
      logic dn;
      dn = 1'b0;
      if (a) begin
         ph = 0; rem = 0;
      end else begin
         case (ph)
            0: if (s) begin ph = 1; rem = PRE; end
            1: begin rem--; if (rem == 0) begin ph = 2; rem = ARMC; end end
            2: begin rem--; if (rem == 0) begin ph = 3; rem = POST; end end
            3: begin rem--; if (rem == 0) begin ph = 4; dn = 1'b1; end end
            4: if (d) begin ph = 5; rem = ARMC; end
            5: begin rem--; if (rem == 0) begin ph = 0; dn = 1'b1; end end
            default: ph = 0;
         endcase
      end
      e.ch    = 32'h0;
      if (ph == 4) e.ch = c;
      else if (ph == 2) e.ch = 32'h0000_00FF;
      e.busy  = (ph == 1) || (ph == 2) || (ph == 3) || (ph == 5);
      e.armed = (ph == 4);
      e.done  = dn;
      e.st    = 3'(ph);
      q.push_back(e);
   endtask

   task automatic drive(input logic s, input logic d, input logic a, input logic [31:0] c);
      @(negedge clock);
      #1;
      start = s; disarm = d; abort = a; ch_in = c;
      model(s, d, a, c);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, $urandom);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ch"},    ch_out, 32'h0);
      check({tag, "_busy"},  {31'h0, busy}, 32'h0);
      check({tag, "_armed"}, {31'h0, armed}, 32'h0);
      check({tag, "_done"},  {31'h0, done}, 32'h0);
      check({tag, "_state"}, {29'h0, state_dbg}, 32'h0);
   endtask

   // Monitor: compare DUT outputs against the oldest pending expectation.
   always @(negedge clock) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("ch_out",    ch_out, e.ch);
         check("busy",      {31'h0, busy}, {31'h0, e.busy});
         check("armed",     {31'h0, armed}, {31'h0, e.armed});
         check("done",      {31'h0, done}, {31'h0, e.done});
         check("state_dbg", {29'h0, state_dbg}, {29'h0, e.st});
      end
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; disarm = 1'b0; abort = 1'b0; ch_in = 32'h0;
      #12;
      check_reset_outputs("reset");
      @(negedge clock); #1; reset_n = 1'b1;

      // Nominal arm sequence with repeated start pulses during PRE/ARM.
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      idle(4);
      drive(1'b0, 1'b0, 1'b0, 32'hA1B2C3D4);
      drive(1'b0, 1'b0, 1'b0, 32'h5566_7788);
      // Start ignored in RUN; start+disarm together takes disarm.
      drive(1'b1, 1'b0, 1'b0, 32'h1234_5678);
      drive(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
      idle(5);

      // Start and disarm together in IDLE: start wins. Abort with start in POST.
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      idle(PRE + ARMC);
      drive(1'b1, 1'b0, 1'b1, 32'h0);
      idle(4);

      // Reset mid-ARM.
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      idle(PRE + 1);
      @(negedge clock); #1;
      reset_n = 1'b0; start = 1'b0; disarm = 1'b0; abort = 1'b0;
      #1;
      check_reset_outputs("midarm_reset");
      ph = 0; rem = 0;
      @(negedge clock); #1;
      check_reset_outputs("midarm_hold");
      reset_n = 1'b1;
      idle(3);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 40) == 0), $urandom);
      end
      idle(2);
      @(negedge clock); #1;
      check("drain", q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
